// File: rtl/multi_timer_unit_pkg.sv
// Shared types for the multi-channel timer: register indices and the
// packed control/status layouts used by the top and every channel.
package timer_v2_types;

    // Per-channel register indices (glob = 0)
    localparam logic [2:0] CTRL        = 3'd0;
    localparam logic [2:0] RELOAD      = 3'd1;
    localparam logic [2:0] COUNT       = 3'd2;
    localparam logic [2:0] STATUS      = 3'd3;
    localparam logic [2:0] CAPTURE     = 3'd4;

    // Global register indices (glob = 1)
    localparam logic [2:0] PRESCALE    = 3'd0;
    localparam logic [2:0] IRQ_PENDING = 3'd1;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } timer_ctrl_t;

    typedef struct packed {
        logic cap;
        logic exp;
    } timer_status_t;

endpackage

// File: rtl/multi_timer_unit_channel.sv
// One timer channel: down counter, reload, control/status, expiry pulse
// and (when TIMER_CAPTURE_EN is defined) the synchronised capture path.
module timer_channel
    import timer_v2_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 wr_en,
    input  logic [2:0]           wr_idx,
    input  logic [CNT_WIDTH-1:0] wr_data,
    input  logic                 capture_in,
    output logic [2:0]           ctrl,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] reload,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] capture,
    output logic                 expired
);

    timer_ctrl_t          ctrl_reg, ctrl_next, ctrl_wr;
    timer_status_t        status_reg, status_next;
    logic [CNT_WIDTH-1:0] reload_reg, reload_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 expired_reg;
    logic                 expiry;
    logic                 cap_edge;
    logic                 wr_ctrl, wr_reload, wr_count, wr_status;

    assign wr_ctrl   = wr_en && (wr_idx == CTRL);
    assign wr_reload = wr_en && (wr_idx == RELOAD);
    assign wr_count  = wr_en && (wr_idx == COUNT);
    assign wr_status = wr_en && (wr_idx == STATUS);

    // Next-state: a COUNT write beats any tick; counting only continues
    // when en is 1 both before and after any CTRL write on this edge.
    always_comb begin
        ctrl_wr     = wr_ctrl ? timer_ctrl_t'(wr_data[2:0]) : ctrl_reg;
        ctrl_next   = ctrl_wr;
        reload_next = wr_reload ? wr_data : reload_reg;
        count_next  = count_reg;
        expiry      = 1'b0;
        if (wr_count) begin
            count_next = wr_data;
        end else if (!ctrl_reg.en && ctrl_wr.en) begin
            count_next = reload_reg;
        end else if (ctrl_reg.en && ctrl_wr.en && tick) begin
            if (count_reg == '0) begin
                expiry = 1'b1;
                if (ctrl_reg.periodic) begin
                    count_next = reload_reg;
                end else if (!wr_ctrl) begin
                    ctrl_next.en = 1'b0;
                end
            end else begin
                count_next = count_reg - 1'b1;
            end
        end
        // W1C first, then set: a same-cycle event keeps the bit set
        status_next.exp = (status_reg.exp & ~(wr_status & wr_data[0])) | expiry;
        status_next.cap = (status_reg.cap & ~(wr_status & wr_data[1])) | cap_edge;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg    <= '0;
            status_reg  <= '0;
            reload_reg  <= '0;
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            status_reg  <= status_next;
            reload_reg  <= reload_next;
            count_reg   <= count_next;
            expired_reg <= expiry;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]           cap_sync_reg;
    logic [CNT_WIDTH-1:0] capture_reg;

    // Two-flop synchroniser followed by one history flop for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_sync_reg <= '0;
        end else begin
            cap_sync_reg <= {cap_sync_reg[1:0], capture_in};
        end
    end

    assign cap_edge = cap_sync_reg[1] & ~cap_sync_reg[2];

    // Latch the value COUNT takes on the detection edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capture_reg <= '0;
        end else if (cap_edge) begin
            capture_reg <= count_next;
        end
    end

    assign capture = capture_reg;
`else
    logic unused_capture_in;
    assign unused_capture_in = capture_in;
    assign cap_edge          = 1'b0;
    assign capture           = '0;
`endif

    assign ctrl    = ctrl_reg;
    assign status  = status_reg;
    assign reload  = reload_reg;
    assign count   = count_reg;
    assign expired = expired_reg;

endmodule

// File: rtl/multi_timer_unit.sv
// NUM_CH timer channels behind a flat single-cycle register port, sharing
// one prescaler. Capture support is built only with TIMER_CAPTURE_EN.
module multi_timer_unit
    import timer_v2_types::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int PRESCALE_WIDTH = 8,
    parameter int ADDR_WIDTH     = $clog2(NUM_CH) + 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_req,
    input  logic                  reg_we,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic                  reg_ack,
    input  logic [NUM_CH-1:0]     capture_in,
    output logic [NUM_CH-1:0]     expired,
    output logic [NUM_CH-1:0]     irq_vec,
    output logic                  irq
);

    localparam int CH_BITS = ADDR_WIDTH - 4;
    localparam int SEL_W   = (CH_BITS > 0) ? CH_BITS : 1;

    logic                      glob;
    logic [2:0]                idx;
    logic [SEL_W-1:0]          ch_sel;
    logic                      ch_valid;
    logic                      wr_prescale;
    logic                      tick;
    logic [PRESCALE_WIDTH-1:0] prescale_reg, pre_cnt_reg;
    logic [31:0]               rdata_next, reg_rdata_reg;
    logic                      reg_ack_reg;
    logic                      unused_wdata;

    logic [2:0]           ch_ctrl    [NUM_CH];
    logic [1:0]           ch_status  [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_reload  [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_count   [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_capture [NUM_CH];

    assign glob         = reg_addr[ADDR_WIDTH-1];
    assign idx          = reg_addr[2:0];
    assign unused_wdata = ^reg_wdata;

    generate
        if (CH_BITS > 0) begin : g_ch_field
            assign ch_sel = reg_addr[ADDR_WIDTH-2:3];
        end else begin : g_no_ch_field
            assign ch_sel = 1'b0;
        end
    endgenerate

    assign ch_valid    = int'(ch_sel) < NUM_CH;
    assign wr_prescale = reg_req && reg_we && glob && (idx == PRESCALE);
    assign tick        = (pre_cnt_reg == prescale_reg);

    // Prescaler: wraps after PRESCALE+1 cycles; a PRESCALE write restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_reg <= '0;
            pre_cnt_reg  <= '0;
        end else if (wr_prescale) begin
            prescale_reg <= reg_wdata[PRESCALE_WIDTH-1:0];
            pre_cnt_reg  <= '0;
        end else begin
            pre_cnt_reg  <= tick ? '0 : pre_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr_en;
            assign wr_en = reg_req && reg_we && !glob && (int'(ch_sel) == gi);

            timer_channel #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .tick       (tick),
                .wr_en      (wr_en),
                .wr_idx     (idx),
                .wr_data    (reg_wdata[CNT_WIDTH-1:0]),
                .capture_in (capture_in[gi]),
                .ctrl       (ch_ctrl[gi]),
                .status     (ch_status[gi]),
                .reload     (ch_reload[gi]),
                .count      (ch_count[gi]),
                .capture    (ch_capture[gi]),
                .expired    (expired[gi])
            );

            assign irq_vec[gi] = ch_status[gi][0] & ch_ctrl[gi][2];
        end
    endgenerate

    assign irq = |irq_vec;

    // Read mux: zero for writes, unmapped indices and absent channels
    always_comb begin
        rdata_next = '0;
        if (reg_req && !reg_we) begin
            if (glob) begin
                case (idx)
                    PRESCALE:    rdata_next = 32'(prescale_reg);
                    IRQ_PENDING: rdata_next = 32'(irq_vec);
                    default:     rdata_next = '0;
                endcase
            end else if (ch_valid) begin
                case (idx)
                    CTRL:    rdata_next = {29'd0, ch_ctrl[ch_sel]};
                    RELOAD:  rdata_next = 32'(ch_reload[ch_sel]);
                    COUNT:   rdata_next = 32'(ch_count[ch_sel]);
                    STATUS:  rdata_next = {30'd0, ch_status[ch_sel]};
                    CAPTURE: rdata_next = 32'(ch_capture[ch_sel]);
                    default: rdata_next = '0;
                endcase
            end
        end
    end

    // Response stage: ack and read data one cycle after the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_ack_reg   <= 1'b0;
            reg_rdata_reg <= '0;
        end else begin
            reg_ack_reg   <= reg_req;
            reg_rdata_reg <= rdata_next;
        end
    end

    assign reg_ack   = reg_ack_reg;
    assign reg_rdata = reg_rdata_reg;

endmodule

// File: tb/tb_multi_timer_unit.sv
// Directed bench for multi_timer_unit (default 4 channels). Inputs are
// driven on the falling edge; outputs are sampled on the falling edge.
module tb_multi_timer_unit;
    import timer_v2_types::*;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_req, reg_we;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata, reg_rdata;
    logic          reg_ack;
    logic [3:0]    capture_in, expired, irq_vec;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0, ta, tb;
    logic [31:0] rd, exp_v;
    logic e0, e3;

    multi_timer_unit #(
        .NUM_CH         (4),
        .CNT_WIDTH      (32),
        .PRESCALE_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .capture_in (capture_in),
        .expired    (expired),
        .irq_vec    (irq_vec),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [AW-1:0] ra(input logic glob, input int ch, input logic [2:0] idx);
        logic [1:0] c;
        c = 2'(ch);
        return {glob, c, idx};
    endfunction

    // One register transaction; call at a falling edge, returns one cycle later
    task automatic reg_xfer(input logic we, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(negedge clk);
        reg_req = 1'b0;
        reg_we  = 1'b0;
        rdata   = reg_rdata;
        check_value("ack", 32'(reg_ack), 32'd1);
        if (we) check_value("wr_rdata_zero", reg_rdata, 32'd0);
        $display("txn %s addr=0x%02h wdata=0x%08h rdata=0x%08h cyc=%0d",
                 we ? "WR" : "RD", addr, wdata, reg_rdata, cyc);
    endtask

    task automatic reg_wr(input logic [AW-1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        reg_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic reg_rd(input logic [AW-1:0] addr, output logic [31:0] data);
        reg_xfer(1'b0, addr, 32'd0, data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; reg_req = 1'b0; reg_we = 1'b0;
        reg_addr = '0; reg_wdata = '0; capture_in = '0;
        repeat (3) @(negedge clk);
        check_value("rst_ack", 32'(reg_ack), 0);
        check_value("rst_rdata", reg_rdata, 0);
        check_value("rst_expired", 32'(expired), 0);
        check_value("rst_irq_vec", 32'(irq_vec), 0);
        check_value("rst_irq", 32'(irq), 0);
        reset = 1'b1;
        @(negedge clk);

        // One-shot on ch0: RELOAD=5, tick every cycle
        reg_wr(ra(1, 0, PRESCALE), 0);
        reg_wr(ra(0, 0, RELOAD), 5);
        reg_wr(ra(0, 0, CTRL), 32'b001);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_value("oneshot_expired", 32'(expired), (k == 6) ? 32'd1 : 32'd0);
        end
        reg_rd(ra(0, 0, COUNT), rd);  check_value("oneshot_count", rd, 0);
        reg_rd(ra(0, 0, CTRL), rd);   check_value("oneshot_ctrl", rd, 0);
        reg_rd(ra(0, 0, STATUS), rd); check_value("oneshot_status", rd, 1);
        check_value("oneshot_irq", 32'(irq), 0);

        // Periodic ch2 with irq: PRESCALE=3, RELOAD=2 -> 12-cycle period
        reg_wr(ra(1, 0, PRESCALE), 3);
        reg_wr(ra(0, 2, RELOAD), 2);
        reg_wr(ra(0, 2, CTRL), 32'b111);
        t0 = cyc;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp_v = (k == 10 || k == 22 || k == 34) ? 32'h4 : 32'h0;
            check_value("periodic_expired", 32'(expired), exp_v);
            if (k == 9)  check_value("periodic_irq_before", 32'(irq), 0);
            if (k == 10) begin
                check_value("periodic_irq_vec", 32'(irq_vec), 32'h4);
                check_value("periodic_irq", 32'(irq), 1);
            end
        end
        reg_rd(ra(1, 0, IRQ_PENDING), rd); check_value("irq_pending", rd, 4);
        reg_wr(ra(0, 2, STATUS), 1);
        check_value("w1c_irq_drop", 32'(irq), 0);
        while (cyc < t0 + 45) @(negedge clk);
        reg_wr(ra(0, 2, STATUS), 1);   // request edge is the t0+46 expiry
        check_value("w1c_collide_expired", 32'(expired), 32'h4);
        check_value("w1c_collide_irq", 32'(irq), 1);
        reg_rd(ra(0, 2, STATUS), rd); check_value("w1c_collide_status", rd, 1);
        reg_wr(ra(0, 2, CTRL), 0);
        reg_wr(ra(0, 2, STATUS), 1);
        check_value("ch2_cleared_irq", 32'(irq), 0);

        // Capture on ch1 while COUNT passes 100
        reg_wr(ra(1, 0, PRESCALE), 0);
        reg_wr(ra(0, 1, RELOAD), 200);
        reg_wr(ra(0, 1, CTRL), 32'b011);
        t0 = cyc;
        while (cyc < t0 + 100) @(negedge clk);
        capture_in = 4'b0010;
        repeat (4) @(negedge clk);
        capture_in = 4'b0000;
        reg_rd(ra(0, 1, CAPTURE), rd);
`ifdef TIMER_CAPTURE_EN
        check_value("capture_value", rd, 97);
        reg_rd(ra(0, 1, STATUS), rd); check_value("capture_status", rd, 2);
`else
        check_value("capture_value", rd, 0);
        reg_rd(ra(0, 1, STATUS), rd); check_value("capture_status", rd, 0);
`endif
        reg_wr(ra(0, 1, CTRL), 0);
        reg_wr(ra(0, 1, STATUS), 3);

        // Collisions on ch1 (every cycle is a tick)
        reg_wr(ra(0, 1, CTRL), 32'b001);
        reg_wr(ra(0, 1, COUNT), 32'h10);
        reg_rd(ra(0, 1, COUNT), rd); check_value("count_write_wins", rd, 32'h10);
        reg_wr(ra(0, 1, COUNT), 0);
        reg_wr(ra(0, 1, CTRL), 0);
        check_value("en_clear_no_expiry", 32'(expired), 0);
        reg_rd(ra(0, 1, STATUS), rd); check_value("en_clear_status", rd, 0);
        reg_wr(ra(0, 1, CTRL), 32'b001);
        reg_wr(ra(0, 1, COUNT), 5);
        reg_wr(ra(0, 1, CTRL), 0);
        reg_rd(ra(0, 1, COUNT), rd); check_value("en_clear_no_decrement", rd, 5);

        // Independent periodic channels: ch0 period 2, ch3 period 8
        reg_wr(ra(0, 0, RELOAD), 1);
        reg_wr(ra(0, 3, RELOAD), 7);
        reg_wr(ra(0, 0, CTRL), 32'b011);
        ta = cyc;
        reg_wr(ra(0, 3, CTRL), 32'b011);
        tb = cyc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            e0 = ((cyc - ta) % 2) == 0;
            e3 = ((cyc - tb) % 8) == 0;
            check_value("multi_expired", 32'(expired), {28'd0, e3, 2'b00, e0});
        end
        reg_rd(ra(0, 0, COUNT), rd);
        check_value("b2b_count_ch0", rd, (((cyc - 1 - ta) % 2) == 0) ? 32'd1 : 32'd0);
        reg_rd(ra(0, 3, COUNT), rd);
        check_value("b2b_count_ch3", rd, 32'(7 - ((cyc - 1 - tb) % 8)));
        @(negedge clk);
        check_value("ack_idle", 32'(reg_ack), 0);

        // Reset asserted mid-count
        reg_wr(ra(0, 3, CTRL), 32'b111);
        check_value("pre_reset_irq", 32'(irq), 1);
        reg_rd(ra(0, 3, CTRL), rd); check_value("pre_reset_ctrl", rd, 7);
        #2;
        reset = 1'b0;
        #1;
        check_value("midrst_ack", 32'(reg_ack), 0);
        check_value("midrst_rdata", reg_rdata, 0);
        check_value("midrst_expired", 32'(expired), 0);
        check_value("midrst_irq_vec", 32'(irq_vec), 0);
        check_value("midrst_irq", 32'(irq), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            for (int i = 0; i < 8; i++) begin
                reg_rd(ra(0, ch, 3'(i)), rd);
                check_value("post_reset_ch_reg", rd, 0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            reg_rd(ra(1, 0, 3'(i)), rd);
            check_value("post_reset_glob_reg", rd, 0);
        end
        check_value("post_reset_expired", 32'(expired), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
